// File: rtl/lms_ctr_oc_mem_pkg.sv
// Shared definitions for the lms_ctr on-chip memory arbiter: memory geometry,
// the out-of-range read pattern and the read-return tag layout.
package lms_ctr_oc_mem_pkg;

   localparam int DEPTH  = 5888;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   localparam logic [DATA_W-1:0] OOR_RDATA = 32'hDEAD_BEEF;

   // Captured on every accepted read; consumed one cycle later to steer the
   // returning word to the port that issued it.
   typedef struct packed {
      logic valid;
      logic port;
      logic oor;
   } rd_tag_t;

endpackage

// File: rtl/lms_ctr_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational in the cycle
// of the request; last_grant remembers the most recent winner so that a tie
// goes to the other port.
module lms_ctr_rr_arb2
   import lms_ctr_oc_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       freeze,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       last_grant
);

   logic last_grant_q;

   // Grant selection: single requester wins, tie goes to the port not granted last.
   always_comb begin
      grant = 2'b00;
      if (!freeze) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // Winner history; starts at 1 so port 0 takes the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else if (grant[0]) begin
         last_grant_q <= 1'b0;
      end else if (grant[1]) begin
         last_grant_q <= 1'b1;
      end
   end

   assign last_grant = last_grant_q;

endmodule

// File: rtl/lms_ctr_oc_mem_arb.sv
// Round-robin Avalon-MM arbiter sharing the single port of the lms_ctr
// on-chip memory between the CPU data port (s0) and the DMA/config loader
// (s1). One access per cycle, one-cycle read latency, out-of-range accesses
// are accepted but never reach the memory.
module lms_ctr_oc_mem_arb
   import lms_ctr_oc_mem_pkg::*;
#(
   parameter int                DEPTH     = lms_ctr_oc_mem_pkg::DEPTH,
   parameter int                ADDR_W    = lms_ctr_oc_mem_pkg::ADDR_W,
   parameter logic [DATA_W-1:0] OOR_RDATA = lms_ctr_oc_mem_pkg::OOR_RDATA
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              freeze,

   input  logic [ADDR_W-1:0] s0_address,
   input  logic [BE_W-1:0]   s0_byteenable,
   input  logic              s0_read,
   input  logic              s0_write,
   input  logic [DATA_W-1:0] s0_writedata,
   output logic              s0_waitrequest,
   output logic [DATA_W-1:0] s0_readdata,
   output logic              s0_readdatavalid,

   input  logic [ADDR_W-1:0] s1_address,
   input  logic [BE_W-1:0]   s1_byteenable,
   input  logic              s1_read,
   input  logic              s1_write,
   input  logic [DATA_W-1:0] s1_writedata,
   output logic              s1_waitrequest,
   output logic [DATA_W-1:0] s1_readdata,
   output logic              s1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,

   output logic              oor_err
);

   // True when the word address lies inside the physical memory.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
      return ({{(32-ADDR_W){1'b0}}, addr} < DEPTH);
   endfunction

   // Returning word: the fixed pattern for blocked reads, memory data otherwise.
   function automatic logic [DATA_W-1:0] rdata_sel(input logic oor,
                                                   input logic [DATA_W-1:0] mem_data);
      return oor ? OOR_RDATA : mem_data;
   endfunction

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              last_grant;
   logic              frz;
   logic              win0;
   logic              win1;

   logic              acc_p0;
   logic              sel_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [BE_W-1:0]   be_p0;
   logic [DATA_W-1:0] wdata_p0;
   logic              wr_p0;
   logic              rd_p0;
   logic              both_p0;
   logic              oor_p0;
   logic [ADDR_W-1:0] addr_hold;

   rd_tag_t           tag_p1;
   logic              oor_err_p1;
   logic              vld_p1;
   logic [DATA_W-1:0] rdata_p1;

   assign req = {s1_read | s1_write, s0_read | s0_write};

   // Reset behaves like freeze so nothing is granted while it is high.
   assign frz = freeze | reset;

   lms_ctr_rr_arb2 u_arb (
      .clk        (clk),
      .reset      (reset),
      .freeze     (frz),
      .req        (req),
      .grant      (grant),
      .last_grant (last_grant)
   );

   // A port would win if it asked now: it wins alone, or on a tie when the
   // other port was granted last. For a requesting port this equals its grant,
   // for an idle port it is the hypothetical result.
   assign win0 = !frz && (req[1] ? last_grant  : 1'b1);
   assign win1 = !frz && (req[0] ? !last_grant : 1'b1);

   assign s0_waitrequest = !win0;
   assign s1_waitrequest = !win1;

   // ---- stage p0: request mux and range check in the grant cycle ----
   // Steer the winning port's fields toward the memory.
   always_comb begin
      acc_p0   = |grant;
      sel_p0   = grant[1];
      addr_p0  = sel_p0 ? s1_address    : s0_address;
      be_p0    = sel_p0 ? s1_byteenable : s0_byteenable;
      wdata_p0 = sel_p0 ? s1_writedata  : s0_writedata;
      wr_p0    = sel_p0 ? s1_write      : s0_write;
      both_p0  = sel_p0 ? (s1_read & s1_write) : (s0_read & s0_write);
      rd_p0    = sel_p0 ? (s1_read & ~s1_write) : (s0_read & ~s0_write);
      oor_p0   = !addr_in_range(addr_p0);
   end

   // Keep the last issued address on the bus while idle.
   always_ff @(posedge clk) begin
      if (acc_p0) begin
         addr_hold <= addr_p0;
      end
   end

   assign mem_address    = acc_p0 ? addr_p0 : addr_hold;
   assign mem_byteenable = be_p0;
   assign mem_writedata  = wdata_p0;
   assign mem_chipselect = acc_p0 && !oor_p0;
   assign mem_write      = acc_p0 && wr_p0;
   assign mem_clken      = 1'b1;

   // ---- stage p1: read tag and error flag, aligned with memory read data ----
   // Tag every accepted read and flag blocked or ambiguous accesses.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_p1     <= '0;
         oor_err_p1 <= 1'b0;
      end else begin
         tag_p1.valid <= acc_p0 && rd_p0;
         tag_p1.port  <= sel_p0;
         tag_p1.oor   <= oor_p0;
         oor_err_p1   <= acc_p0 && (oor_p0 || both_p0);
      end
   end

   // A read in flight when reset rises must not surface.
   assign vld_p1   = tag_p1.valid && !reset;
   assign rdata_p1 = rdata_sel(tag_p1.oor, mem_readdata);

   assign s0_readdatavalid = vld_p1 && !tag_p1.port;
   assign s1_readdatavalid = vld_p1 &&  tag_p1.port;
   assign s0_readdata      = s0_readdatavalid ? rdata_p1 : '0;
   assign s1_readdata      = s1_readdatavalid ? rdata_p1 : '0;

   assign oor_err = oor_err_p1 && !reset;

endmodule

// File: tb/tb_lms_ctr_oc_mem_arb.sv
// Directed bench for lms_ctr_oc_mem_arb with a behavioural single-port memory.
module tb_lms_ctr_oc_mem_arb;

   logic        clk;
   logic        reset;
   logic        freeze;
   logic [12:0] s0_address;
   logic [3:0]  s0_byteenable;
   logic        s0_read;
   logic        s0_write;
   logic [31:0] s0_writedata;
   logic        s0_waitrequest;
   logic [31:0] s0_readdata;
   logic        s0_readdatavalid;
   logic [12:0] s1_address;
   logic [3:0]  s1_byteenable;
   logic        s1_read;
   logic        s1_write;
   logic [31:0] s1_writedata;
   logic        s1_waitrequest;
   logic [31:0] s1_readdata;
   logic        s1_readdatavalid;
   logic [12:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;
   logic        oor_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   lms_ctr_oc_mem_arb dut (
      .clk              (clk),
      .reset            (reset),
      .freeze           (freeze),
      .s0_address       (s0_address),
      .s0_byteenable    (s0_byteenable),
      .s0_read          (s0_read),
      .s0_write         (s0_write),
      .s0_writedata     (s0_writedata),
      .s0_waitrequest   (s0_waitrequest),
      .s0_readdata      (s0_readdata),
      .s0_readdatavalid (s0_readdatavalid),
      .s1_address       (s1_address),
      .s1_byteenable    (s1_byteenable),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_writedata     (s1_writedata),
      .s1_waitrequest   (s1_waitrequest),
      .s1_readdata      (s1_readdata),
      .s1_readdatavalid (s1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata),
      .oor_err          (oor_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 5888x32 memory, registered read.
   logic [31:0] mem_arr [0:5887];
   logic [31:0] mem_rd;
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken && ({19'b0, mem_address} < 32'd5888)) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_rd <= mem_arr[mem_address];
         end
      end
   end
   assign mem_readdata = mem_rd;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1; freeze = 1'b0;
      s0_address = '0; s0_byteenable = 4'hF; s0_read = 1'b0; s0_write = 1'b0; s0_writedata = '0;
      s1_address = '0; s1_byteenable = 4'hF; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0;

      // reset state, even with a request pending
      tick;
      s0_read = 1'b1; s0_address = 13'h10; #1;
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_wait0", s0_waitrequest, 1);
      chk("rst_rdv0", s0_readdatavalid, 0);
      chk("rst_rdv1", s1_readdatavalid, 0);
      chk("rst_oor", oor_err, 0);
      tick;
      s0_read = 1'b0; reset = 1'b0; #1;
      chk("idle_wait0", s0_waitrequest, 0);
      chk("idle_wait1", s1_waitrequest, 0);
      chk("idle_clken", mem_clken, 1);

      // port 0 write then read back
      s0_write = 1'b1; s0_address = 13'h10; s0_writedata = 32'h12345678; s0_byteenable = 4'hF; #1;
      chk("wr_wait0", s0_waitrequest, 0);
      chk("wr_cs", mem_chipselect, 1);
      chk("wr_we", mem_write, 1);
      chk("wr_addr", mem_address, 32'h10);
      tick;
      s0_write = 1'b0; s0_read = 1'b1; #1;
      chk("rd_wait0", s0_waitrequest, 0);
      chk("rd_we", mem_write, 0);
      tick;
      s0_read = 1'b0; #1;
      chk("rd_rdv0", s0_readdatavalid, 1);
      chk("rd_data0", s0_readdata, 32'h12345678);
      chk("rd_rdv1", s1_readdatavalid, 0);
      chk("rd_data1", s1_readdata, 0);
      chk("idle_addr_hold", mem_address, 32'h10);

      // read followed by write to the same address sees old data
      s0_read = 1'b1; tick;
      s0_read = 1'b0; s0_write = 1'b1; s0_writedata = 32'h0F0F0F0F; #1;
      chk("raw_rdv0", s0_readdatavalid, 1);
      chk("raw_data0", s0_readdata, 32'h12345678);
      tick;
      s0_write = 1'b0; #1;
      chk("raw_no_wresp", s0_readdatavalid, 0);
      s0_read = 1'b1; tick;
      s0_read = 1'b0; #1;
      chk("raw_new_data", s0_readdata, 32'h0F0F0F0F);

      // preload words 1 and 2
      s0_write = 1'b1; s0_address = 13'd1; s0_writedata = 32'h11111111; tick;
      s0_address = 13'd2; s0_writedata = 32'h22222222; tick;
      s0_write = 1'b0; reset = 1'b1; tick;
      reset = 1'b0;

      // both ports reading continuously from reset: 0,1,0,1
      s0_read = 1'b1; s0_address = 13'd1; s1_read = 1'b1; s1_address = 13'd2; #1;
      chk("rr0_wait0", s0_waitrequest, 0);
      chk("rr0_wait1", s1_waitrequest, 1);
      tick; #1;
      chk("rr1_rdv0", s0_readdatavalid, 1);
      chk("rr1_data0", s0_readdata, 32'h11111111);
      chk("rr1_wait0", s0_waitrequest, 1);
      chk("rr1_wait1", s1_waitrequest, 0);
      tick; #1;
      chk("rr2_rdv1", s1_readdatavalid, 1);
      chk("rr2_data1", s1_readdata, 32'h22222222);
      chk("rr2_rdv0", s0_readdatavalid, 0);
      chk("rr2_wait0", s0_waitrequest, 0);
      chk("rr2_wait1", s1_waitrequest, 1);
      tick; #1;
      chk("rr3_data0", s0_readdata, 32'h11111111);
      chk("rr3_wait1", s1_waitrequest, 0);
      tick;
      s0_read = 1'b0; s1_read = 1'b0; #1;
      chk("rr4_data1", s1_readdata, 32'h22222222);

      // port 1 partial write over zero
      s1_write = 1'b1; s1_address = 13'h20; s1_writedata = 32'h0; s1_byteenable = 4'hF; tick;
      s1_writedata = 32'hAABBCCDD; s1_byteenable = 4'b0101; #1;
      chk("be_mem", mem_byteenable, 32'h5);
      tick;
      s1_write = 1'b0; s1_read = 1'b1; tick;

      // freeze with both requesting; tagged read still returns
      freeze = 1'b1; s0_read = 1'b1; s0_address = 13'd1; s1_address = 13'd2; #1;
      chk("be_rdv1", s1_readdatavalid, 1);
      chk("be_data1", s1_readdata, 32'h00BB00DD);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            tick;
            chk("frz_rdv1", s1_readdatavalid, 0);
         end
         chk("frz_wait0", s0_waitrequest, 1);
         chk("frz_wait1", s1_waitrequest, 1);
         chk("frz_cs", mem_chipselect, 0);
      end
      tick;
      freeze = 1'b0; #1;
      chk("rel_wait0", s0_waitrequest, 0);
      chk("rel_wait1", s1_waitrequest, 1);
      tick; #1;
      chk("rel_data0", s0_readdata, 32'h11111111);
      chk("rel_wait1b", s1_waitrequest, 0);
      tick;
      s0_read = 1'b0; s1_read = 1'b0; #1;
      chk("rel_data1", s1_readdata, 32'h22222222);

      // out-of-range read at DEPTH
      s0_read = 1'b1; s0_address = 13'd5888; #1;
      chk("oor_cs", mem_chipselect, 0);
      chk("oor_wait0", s0_waitrequest, 0);
      chk("oor_err_early", oor_err, 0);
      tick;
      s0_read = 1'b0; #1;
      chk("oor_err", oor_err, 1);
      chk("oor_rdv0", s0_readdatavalid, 1);
      chk("oor_data0", s0_readdata, 32'hDEADBEEF);
      tick; #1;
      chk("oor_err_once", oor_err, 0);

      // out-of-range write is dropped
      s0_write = 1'b1; s0_address = 13'd6000; s0_writedata = 32'h55555555; s0_byteenable = 4'hF; #1;
      chk("oorw_cs", mem_chipselect, 0);
      tick;
      s0_write = 1'b0; #1;
      chk("oorw_err", oor_err, 1);
      s0_read = 1'b1; s0_address = 13'h10; tick;
      s0_read = 1'b0; #1;
      chk("oorw_mem_kept", s0_readdata, 32'h0F0F0F0F);

      // read and write together: treated as write, flagged
      s1_read = 1'b1; s1_write = 1'b1; s1_address = 13'h30; s1_writedata = 32'h77; #1;
      chk("both_we", mem_write, 1);
      tick;
      s1_read = 1'b0; s1_write = 1'b0; #1;
      chk("both_err", oor_err, 1);
      chk("both_rdv1", s1_readdatavalid, 0);

      // reset the cycle after an out-of-range read is accepted
      s0_read = 1'b1; s0_address = 13'd5888; tick;
      s0_read = 1'b0; reset = 1'b1; #1;
      chk("rstf_rdv0", s0_readdatavalid, 0);
      chk("rstf_err", oor_err, 0);
      tick;
      reset = 1'b0; #1;
      chk("rstf_rdv0_after", s0_readdatavalid, 0);
      chk("rstf_err_after", oor_err, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
